// File: rtl/data_mem_arbiter_pkg.sv
// Shared constants and types for the data memory arbiter slice.
package data_mem_pkg;

   localparam int ADDR_W = 8;
   localparam int DATA_W = 16;
   localparam int DEPTH  = 64;

   localparam logic PORT_CPU = 1'b0;
   localparam logic PORT_DBG = 1'b1;

   typedef enum logic {
      IDLE   = 1'b0,
      ACCESS = 1'b1
   } state_t;

endpackage

// File: rtl/data_mem_arbiter_if.sv
// Requester and memory-side signal bundle of the data memory arbiter.
interface data_mem_arbiter_if #(
   parameter int ADDR_W = data_mem_pkg::ADDR_W,
   parameter int DATA_W = data_mem_pkg::DATA_W
);
   logic              p0_req;
   logic              p0_we;
   logic [ADDR_W-1:0] p0_addr;
   logic [DATA_W-1:0] p0_wdata;
   logic              p0_gnt;
   logic              p0_done;
   logic [DATA_W-1:0] p0_rdata;
   logic              p0_err;

   logic              p1_req;
   logic              p1_we;
   logic [ADDR_W-1:0] p1_addr;
   logic [DATA_W-1:0] p1_wdata;
   logic              p1_gnt;
   logic              p1_done;
   logic [DATA_W-1:0] p1_rdata;
   logic              p1_err;

   logic              mem_we;
   logic              mem_re;
   logic [ADDR_W-1:0] mem_addr;
   logic [DATA_W-1:0] mem_wdata;
   logic [DATA_W-1:0] mem_rdata;
   logic              busy;

   modport slave (
      input  p0_req, p0_we, p0_addr, p0_wdata,
      input  p1_req, p1_we, p1_addr, p1_wdata,
      input  mem_rdata,
      output p0_gnt, p0_done, p0_rdata, p0_err,
      output p1_gnt, p1_done, p1_rdata, p1_err,
      output mem_we, mem_re, mem_addr, mem_wdata, busy
   );

   modport master (
      output p0_req, p0_we, p0_addr, p0_wdata,
      output p1_req, p1_we, p1_addr, p1_wdata,
      output mem_rdata,
      input  p0_gnt, p0_done, p0_rdata, p0_err,
      input  p1_gnt, p1_done, p1_rdata, p1_err,
      input  mem_we, mem_re, mem_addr, mem_wdata, busy
   );

endinterface

// File: rtl/data_mem_arbiter_rr_arbiter2.sv
// Combinational two-way winner select: round-robin on ties, or port 0 priority.
module rr_arbiter2 #(
   parameter int FIXED_PRIO = 0
) (
   input  logic [1:0] req,
   input  logic       lastOwner,
   output logic       valid,
   output logic       winner
);
   import data_mem_pkg::*;

   always_comb begin
      valid  = |req;
      winner = PORT_CPU;
      if (req == 2'b10) begin
         winner = PORT_DBG;
      end else if (req == 2'b11 && FIXED_PRIO == 0) begin
         winner = ~lastOwner;
      end
   end

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter and two-cycle access sequencer for the 64 x 16 data memory.
module data_mem_arbiter #(
   parameter int ADDR_W     = data_mem_pkg::ADDR_W,
   parameter int DATA_W     = data_mem_pkg::DATA_W,
   parameter int DEPTH      = data_mem_pkg::DEPTH,
   parameter int FIXED_PRIO = 0
) (
   input logic               clk,
   input logic               reset,
   data_mem_arbiter_if.slave bus
);
   import data_mem_pkg::*;

   // One extra bit so DEPTH = 2**ADDR_W still compares correctly.
   localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

   state_t            state, nextState;
   logic              owner, lastOwner, errFlag, ownerWe;
   logic              grantValid, winner;
   logic [1:0]        req;
   logic              winWe, winErr;
   logic [ADDR_W-1:0] winAddr;
   logic [DATA_W-1:0] winWdata;

   assign req      = {bus.p1_req, bus.p0_req};
   assign bus.busy = (state == ACCESS);

   rr_arbiter2 #(.FIXED_PRIO(FIXED_PRIO)) uArb (
      .req       (req),
      .lastOwner (lastOwner),
      .valid     (grantValid),
      .winner    (winner)
   );

   always_comb begin
      winWe    = bus.p0_we;
      winAddr  = bus.p0_addr;
      winWdata = bus.p0_wdata;
      if (winner == PORT_DBG) begin
         winWe    = bus.p1_we;
         winAddr  = bus.p1_addr;
         winWdata = bus.p1_wdata;
      end
      winErr = ({1'b0, winAddr} >= DEPTH_L);

      nextState = state;
      case (state)
         IDLE:    if (grantValid) nextState = ACCESS;
         ACCESS:  nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= nextState;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         bus.mem_we    <= 1'b0;
         bus.mem_re    <= 1'b0;
         bus.mem_addr  <= '0;
         bus.mem_wdata <= '0;
         bus.p0_gnt    <= 1'b0;
         bus.p1_gnt    <= 1'b0;
         bus.p0_done   <= 1'b0;
         bus.p1_done   <= 1'b0;
         bus.p0_err    <= 1'b0;
         bus.p1_err    <= 1'b0;
         bus.p0_rdata  <= '0;
         bus.p1_rdata  <= '0;
         owner         <= PORT_CPU;
         lastOwner     <= PORT_DBG;
         errFlag       <= 1'b0;
         ownerWe       <= 1'b0;
      end else begin
         bus.mem_we  <= 1'b0;
         bus.mem_re  <= 1'b0;
         bus.p0_gnt  <= 1'b0;
         bus.p1_gnt  <= 1'b0;
         bus.p0_done <= 1'b0;
         bus.p1_done <= 1'b0;
         bus.p0_err  <= 1'b0;
         bus.p1_err  <= 1'b0;

         if (state == IDLE && grantValid) begin
            bus.mem_addr  <= winAddr;
            bus.mem_wdata <= winWdata;
            bus.mem_we    <= winWe && !winErr;
            bus.mem_re    <= !winWe && !winErr;
            bus.p0_gnt    <= (winner == PORT_CPU);
            bus.p1_gnt    <= (winner == PORT_DBG);
            owner         <= winner;
            lastOwner     <= winner;
            errFlag       <= winErr;
            ownerWe       <= winWe;
         end

         // Completion: memory data was driven on the mid-ACCESS negedge.
         if (state == ACCESS) begin
            if (owner == PORT_CPU) begin
               bus.p0_done <= 1'b1;
               bus.p0_err  <= errFlag;
               if (!ownerWe) bus.p0_rdata <= errFlag ? '0 : bus.mem_rdata;
            end else begin
               bus.p1_done <= 1'b1;
               bus.p1_err  <= errFlag;
               if (!ownerWe) bus.p1_rdata <= errFlag ? '0 : bus.mem_rdata;
            end
         end
      end
   end

endmodule
